// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and elaboration helpers for the FFT pair buffer
package fft_pkg;

  // Component width of the canonical complex sample type.
  localparam int CPLX_W = 16;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } pair_state_t;

  // True when v is a non-zero power of two; used to reject bad FRAME_LEN.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fft_half_frame_ram.sv
// rtl/fft_half_frame_ram.sv - half-frame sample store, sync write, async read
module fft_half_frame_ram #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  generate
    if (DEPTH == 1) begin : g_single
      logic [W-1:0] mem0;

      // Single-entry store: the address is always zero, so it is ignored.
      always_ff @(posedge clk) begin
        if (we) mem0 <= wdata;
      end

      assign rdata = mem0;

      logic unused_addr;
      assign unused_addr = ^{waddr, raddr};
    end else begin : g_array
      logic [W-1:0] mem [DEPTH];

      // Write the accepted first-half sample at its frame position.
      always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
      end

      assign rdata = mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/fft_pair_buffer.sv
// rtl/fft_pair_buffer.sv - buffers the first half of a frame and emits butterfly input pairs
module fft_pair_buffer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_LEN  = 8,
  parameter int IDX_W      = (FRAME_LEN / 2 > 1) ? $clog2(FRAME_LEN / 2) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_real,
  input  logic signed [DATA_WIDTH-1:0] in_imag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] real_out0,
  output logic signed [DATA_WIDTH-1:0] imag_out0,
  output logic signed [DATA_WIDTH-1:0] real_out1,
  output logic signed [DATA_WIDTH-1:0] imag_out1,
  output logic [IDX_W-1:0]             pair_idx,
  output logic                         pair_first,
  output logic                         pair_last
);

  localparam int HALF = FRAME_LEN / 2;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HALF - 1);

  generate
    if (!is_pow2(FRAME_LEN) || FRAME_LEN < 2) begin : g_bad_frame_len
      $error("fft_pair_buffer: FRAME_LEN must be a power of two and at least 2");
    end
  endgenerate

  pair_state_t             state;
  logic [IDX_W-1:0]        idx;
  logic                    in_xfer;
  logic                    out_xfer;
  logic                    idx_at_last;
  logic                    ram_we;
  logic [2*DATA_WIDTH-1:0] ram_wdata;
  logic [2*DATA_WIDTH-1:0] ram_rdata;

  // In PAIR a new sample needs the output register free (or draining this cycle);
  // in FILL the register is untouched, so samples flow regardless of out_valid.
  assign in_ready    = (state == FILL) ? en : (en & (~out_valid | out_ready));
  assign in_xfer     = in_valid & in_ready;
  assign out_xfer    = out_valid & out_ready & en;
  assign idx_at_last = (idx == IDX_LAST);
  assign ram_we      = in_xfer & (state == FILL);
  assign ram_wdata   = {in_real, in_imag};

  fft_half_frame_ram #(
    .DEPTH (HALF),
    .AW    (IDX_W),
    .W     (2 * DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (idx),
    .wdata (ram_wdata),
    .raddr (idx),
    .rdata (ram_rdata)
  );

  // Frame sequencer and single-entry output register; a reload in the same cycle
  // as an output transfer wins so full throughput is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      idx        <= '0;
      out_valid  <= 1'b0;
      real_out0  <= '0;
      imag_out0  <= '0;
      real_out1  <= '0;
      imag_out1  <= '0;
      pair_idx   <= '0;
      pair_first <= 1'b0;
      pair_last  <= 1'b0;
    end else if (en) begin
      if (out_xfer) out_valid <= 1'b0;

      if (in_xfer) begin
        idx <= idx_at_last ? '0 : idx + 1'b1;

        case (state)
          FILL: begin
            if (idx_at_last) state <= PAIR;
          end
          PAIR: begin
            real_out0  <= ram_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
            imag_out0  <= ram_rdata[DATA_WIDTH-1:0];
            real_out1  <= in_real;
            imag_out1  <= in_imag;
            pair_idx   <= idx;
            pair_first <= (idx == '0);
            pair_last  <= idx_at_last;
            out_valid  <= 1'b1;
            if (idx_at_last) state <= FILL;
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule
